ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage directly downstream of `icache`. Holds the program counter, drives the icache combinational read port, and buffers fetched instructions with their PCs in a 2-entry queue. Hands them to decode over a valid/ready handshake. Supports start/stop control and PC redirect with flush.

## Interface
- `ADDR_W`, 5: PC / icache address width. Matches the icache `address` type; 32 entries.
- `INSTR_W`, 32: instruction width. Matches the icache `instruction` type.
- `clk`  in  1  clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  pulse: IDLE -> RUN.
- `stop`  in  1  pulse: RUN -> IDLE; no further fetches.
- `redirect`  in  1  load PC from `redirect_pc` and flush queue.
- `redirect_pc`  in  ADDR_W  new PC.
- `ic_read_addr`  out  ADDR_W  icache read address; equals PC register.
- `ic_read_data`  in  INSTR_W  icache read data; combinational from `ic_read_addr`.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  decode accepts head.
- `out_instr`  out  INSTR_W  head instruction.
- `out_pc`  out  ADDR_W  head PC.
- `running`  out  1  state == RUN.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
- State transitions:
  - IDLE -> RUN on `start`.
  - RUN -> IDLE on `stop`.
  - `start` in RUN is ignored.
  - `stop` in IDLE is ignored.
  - `start` and `stop` together: `stop` wins, and state = IDLE next cycle.
- `pop` = `out_valid && out_ready && !redirect`.
- `fire` = state==RUN && !stop && !redirect && (count<2 || pop).
- On `fire`:
  - push {PC, `ic_read_data`} at queue tail.
  - PC <= PC+1, wrapping modulo 2^ADDR_W (31 -> 0 at default).
- On `pop`: head removed; `count` updated with push and pop in the same cycle (count unchanged if both occur).
- On `redirect`, in any state:
  - PC <= `redirect_pc`.
  - count <= 0.
  - Concurrent pop and fire are suppressed.
- Redirect + `start` same cycle: RUN with PC = `redirect_pc`, no fetch that cycle.
- Redirect + `stop` same cycle: IDLE with PC = `redirect_pc`, queue empty.
- In IDLE, queued entries still drain normally via handshake.
- Queue: 2 entries of {ADDR_W PC, INSTR_W instr}, circular with 1-bit head/tail pointers, 2-bit count.
  - `out_valid` = count != 0.
  - `out_instr`/`out_pc` come from the head entry. Both are undefined when `out_valid` = 0; the bench must not check them then.
- `out_instr`/`out_pc` are stable while `out_valid && !out_ready`, unless `redirect` is asserted.

## Timing
- Reset values (async, immediate):
  - state IDLE, PC 0, count 0, pointers 0.
  - `ic_read_addr` 0, `out_valid` 0, `running` 0.
  - Queue storage 0, so `out_instr`/`out_pc` read 0.
- `ic_read_addr` changes only on clk edge (registered PC). Icache read is same-cycle.
- Fetch latency: fire at cycle N -> entry visible with `out_valid` = 1 at N+1.
- Start latency: `start` at N -> first fire at N+1 -> `out_valid` at N+2.
- Redirect latency: `redirect` at N -> `out_valid` = 0 at N+1; first new-PC instruction valid at N+2 (if RUN).
- Throughput: 1 instruction/cycle with `out_ready` held high.
- Full queue (count 2) and no pop: PC holds, no fire.
- Reset mid-operation: all state returns to reset values asynchronously; in-flight entries are lost.

## Configuration
- `IFETCH_PERF_EN` defined adds two output ports and two counters:
  - `perf_fetches` out 16: increments on each `fire`.
  - `perf_stalls` out 16: increments each RUN cycle in which `fire` = 0 because the queue is full.
  - Both saturate at 16'hFFFF and reset to 0.
  - Neither is cleared by `redirect`, `start` or `stop`.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, preload icache[k] = 32'h1000+k, `start`, `out_ready` = 1:
  - `out_valid` first rises 2 cycles after `start`.
  - Sequence is (pc 0, 32'h1000), (1, 32'h1001), … one per cycle.
  - After (31, 32'h101F) the sequence wraps to (0, 32'h1000).
- Backpressure: run with `out_ready` = 0 for 5 cycles:
  - count reaches 2; `ic_read_addr` stays at 2.
  - Head holds (0, 32'h1000).
  - Raising `out_ready` delivers 0, 1, 2 in order with no gaps and no duplicates.
- Redirect to 20 with 2 entries queued and `out_ready` = 1 in the same cycle:
  - No pop occurs; `out_valid` = 0 next cycle.
  - The cycle after that shows (20, 32'h1014).
- `start` and `stop` in the same cycle from IDLE: `running` stays 0 and `ic_read_addr` stays 0. `stop` while 2 entries are queued: both entries drain, then no further valid.
- Assert `nrst` low mid-stream with the queue full: `out_valid`, `running` and `ic_read_addr` are 0 immediately, without a clock edge.
- With `IFETCH_PERF_EN`: 10 free-running fetches followed by 4 full-stall cycles gives `perf_fetches` = 12 (2 queued during the stall) and `perf_stalls` = 4.

Source files
------------

// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: icache combinational read port plus the valid/ready
// hand-off from fetch to decode.
interface ifetch_if #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  ic_read_addr;
  logic [INSTR_W-1:0] ic_read_data;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output ic_read_addr, out_valid, out_instr, out_pc,
    input  ic_read_data, out_ready
  );

  modport slave (
    input  ic_read_addr, out_valid, out_instr, out_pc,
    output ic_read_data, out_ready
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: PC register, icache read, 2-entry {pc, instr} queue to decode.
// Optional IFETCH_PERF_EN adds saturating fetch/stall counters.
module ifetch #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              stop,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  ifetch_if.master          bus,
  output logic              running
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetches,
  output logic [15:0]       perf_stalls
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  entry_t [1:0]      q_mem;
  logic              head_q, tail_q;
  logic [1:0]        count_q;
  logic              valid, pop, fire;

  // stop dominates start
  always_comb begin
    state_d = state_q;
    if (stop)       state_d = IDLE;
    else if (start) state_d = RUN;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign valid = (count_q != 2'd0);
  assign pop   = valid && bus.out_ready && !redirect;
  assign fire  = (state_q == RUN) && !stop && !redirect && ((count_q != 2'd2) || pop);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)         pc_q <= '0;
    else if (redirect) pc_q <= redirect_pc;
    else if (fire)     pc_q <= pc_q + ADDR_W'(1);
  end

  // Flush realigns both pointers so an empty queue always has head == tail.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else if (redirect) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (fire) tail_q <= ~tail_q;
      if (pop)  head_q <= ~head_q;
      unique case ({fire, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)     q_mem <= '0;
    else if (fire) q_mem[tail_q] <= '{pc: pc_q, instr: bus.ic_read_data};
  end

  assign bus.ic_read_addr = pc_q;
  assign bus.out_valid    = valid;
  assign bus.out_instr    = q_mem[head_q].instr;
  assign bus.out_pc       = q_mem[head_q].pc;
  assign running          = (state_q == RUN);

`ifdef IFETCH_PERF_EN
  logic stall;

  // A stall is a RUN cycle that would have fetched but for a full, non-draining queue.
  assign stall = (state_q == RUN) && !stop && !redirect && (count_q == 2'd2) && !pop;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_fetches <= 16'd0;
      perf_stalls  <= 16'd0;
    end else begin
      if (fire  && perf_fetches != 16'hFFFF) perf_fetches <= perf_fetches + 16'd1;
      if (stall && perf_stalls  != 16'hFFFF) perf_stalls  <= perf_stalls  + 16'd1;
    end
  end
`endif

  a_count_range: assert property (@(posedge clk) disable iff (!nrst) count_q != 2'd3);

  a_head_hold: assert property (@(posedge clk) disable iff (!nrst)
    (valid && !bus.out_ready && !redirect) |=> ($stable(bus.out_pc) && $stable(bus.out_instr)));

endmodule

// File: tb/tb_ifetch.sv
// Randomized + directed bench for ifetch against a queue-based behavioural model.
module tb_ifetch;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, redirect = 1'b0;
  logic [4:0] redirect_pc = 5'd0;
  logic       running;
  logic       chk_en = 1'b0;
`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetches, perf_stalls;
`endif

  int n_chk = 0;
  int n_fail = 0;

  ifetch_if #(.ADDR_W(5), .INSTR_W(32)) bus ();

  logic [31:0] mem [32];
  assign bus.ic_read_data = mem[bus.ic_read_addr];

  ifetch #(.ADDR_W(5), .INSTR_W(32)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .start       (start),
    .stop        (stop),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus),
    .running     (running)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetches(perf_fetches),
    .perf_stalls (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: a plain FIFO of {pc, instr}, a run flag and a PC.
  typedef struct packed { logic [4:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic        m_run;
  logic [4:0]  m_pc;
  int unsigned m_fetch, m_stall;
  bit          m_pop, m_fire;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mq.delete();
      m_run = 1'b0; m_pc = 5'd0; m_fetch = 0; m_stall = 0;
    end else begin
      m_pop  = (mq.size() != 0) && bus.out_ready && !redirect;
      m_fire = m_run && !stop && !redirect && (mq.size() < 2 || m_pop);
      if (m_fire && m_fetch < 65535) m_fetch++;
      if (m_run && !stop && !redirect && !m_fire && m_stall < 65535) m_stall++;
      if (redirect) begin
        mq.delete();
        m_pc = redirect_pc;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_fire) begin
          mq.push_back('{pc: m_pc, instr: mem[m_pc]});
          m_pc = m_pc + 5'd1;
        end
      end
      if (stop)       m_run = 1'b0;
      else if (start) m_run = 1'b1;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("running", 64'(running), 64'(m_run));
      chk("ic_read_addr", 64'(bus.ic_read_addr), 64'(m_pc));
      chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("out_pc", 64'(bus.out_pc), 64'(mq[0].pc));
        chk("out_instr", 64'(bus.out_instr), 64'(mq[0].instr));
      end
`ifdef IFETCH_PERF_EN
      chk("perf_fetches", 64'(perf_fetches), 64'(m_fetch));
      chk("perf_stalls", 64'(perf_stalls), 64'(m_stall));
`endif
    end
  end

  task automatic tick(bit st, bit sp, bit rd, logic [4:0] rpc, bit rdy);
    @(negedge clk);
    start = st; stop = sp; redirect = rd; redirect_pc = rpc; bus.out_ready = rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; stop = 0; redirect = 0; bus.out_ready = 0;
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    logic [4:0] e;
    for (int k = 0; k < 32; k++) mem[k] = 32'h1000 + k;
    bus.out_ready = 1'b0;
    #1 nrst = 1'b0;
    #1;
    chk("reset_running", 64'(running), 64'd0);
    chk("reset_addr", 64'(bus.ic_read_addr), 64'd0);
    chk("reset_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    chk_en = 1'b1;

    // start latency, streaming order and PC wrap
    tick(1, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    chk("start_lat_valid0", 64'(bus.out_valid), 64'd0);
    chk("start_running", 64'(running), 64'd1);
    tick(0, 0, 0, 0, 1);
    chk("start_lat_valid1", 64'(bus.out_valid), 64'd1);
    chk("first_pc", 64'(bus.out_pc), 64'd0);
    chk("first_instr", 64'(bus.out_instr), 64'h1000);
    for (int i = 1; i <= 33; i++) begin
      tick(0, 0, 0, 0, 1);
      e = 5'(i);
      chk("stream_pc", 64'(bus.out_pc), 64'(e));
      chk("stream_instr", 64'(bus.out_instr), 64'(32'h1000 + e));
    end

    // backpressure from a fresh PC 0
    tick(0, 1, 1, 0, 0);
    tick(1, 0, 0, 0, 0);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_addr", 64'(bus.ic_read_addr), 64'd0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);
    chk("bp_addr_hold", 64'(bus.ic_read_addr), 64'd2);
    chk("bp_head_pc", 64'(bus.out_pc), 64'd0);
    chk("bp_head_instr", 64'(bus.out_instr), 64'h1000);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 1);
      chk("bp_drain_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_drain_pc", 64'(bus.out_pc), 64'(i));
    end

    // redirect with a full queue and ready high
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
    tick(0, 0, 1, 20, 1);
    tick(0, 0, 0, 0, 1);
    chk("redir_valid0", 64'(bus.out_valid), 64'd0);
    tick(0, 0, 0, 0, 1);
    chk("redir_valid1", 64'(bus.out_valid), 64'd1);
    chk("redir_pc", 64'(bus.out_pc), 64'd20);
    chk("redir_instr", 64'(bus.out_instr), 64'h1014);

    // stop with two entries queued: both drain, then nothing
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    chk("stop_drain0", 64'(bus.out_valid), 64'd1);
    tick(0, 0, 0, 0, 1);
    chk("stop_drain1", 64'(bus.out_valid), 64'd1);
    tick(0, 0, 0, 0, 1);
    chk("stop_empty", 64'(bus.out_valid), 64'd0);
    chk("stop_idle", 64'(running), 64'd0);

    // start and stop together from IDLE
    tick(0, 0, 1, 0, 1);
    tick(1, 1, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 0, 0, 1);
      chk("ss_running", 64'(running), 64'd0);
      chk("ss_addr", 64'(bus.ic_read_addr), 64'd0);
    end

    // counters: 11 streaming fetches, then one more fills the queue, then 4 stalls
    do_reset();
    tick(1, 0, 0, 0, 1);
    for (int i = 0; i < 11; i++) tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
`ifdef IFETCH_PERF_EN
    chk("perf_fetches_lit", 64'(perf_fetches), 64'd12);
    chk("perf_stalls_lit", 64'(perf_stalls), 64'd4);
`endif

    // async reset mid-stream with a full queue
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    chk("pre_rst_running", 64'(running), 64'd1);
    #2 nrst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_running", 64'(running), 64'd0);
    chk("async_rst_addr", 64'(bus.ic_read_addr), 64'd0);
    @(negedge clk);
    nrst = 1'b1;

    // randomized traffic with random icache contents
    for (int k = 0; k < 32; k++) mem[k] = $urandom;
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)),
           ($urandom_range(0, 9) < 6));
    end

    tick(0, 0, 0, 0, 0);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
